// File: rtl/mult_div_unit_if.sv
// E-stage <-> multiply/divide unit signal bundle.
// Issue contract: an op presented on MDOp is taken on the rising edge
// when Kill = 0 and Busy = 0. Start flags that a MULT/MULTU/DIV/DIVU
// will be taken this cycle. Busy stays high while a result is pending.
// HI/LO always carry the architectural register values.
interface mult_div_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Kill;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // E stage drives operands/op and observes status and HI/LO
    modport master (
        output A, B, MDOp, Kill,
        input  Start, Busy, HI, LO
    );

    // The unit itself
    modport slave (
        input  A, B, MDOp, Kill,
        output Start, Busy, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Results are computed combinationally at issue and parked in hi_tmp/lo_tmp.
// A down-counter models the fixed pipeline latency; HI/LO are committed
// when the counter expires, so the rest of the pipeline sees a
// multi-cycle unit.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_tmp;
    logic [31:0] lo_tmp;
    logic [3:0]  cnt;
    logic        busy_q;
    logic        dbz_q;      // pending divide had a zero divisor: skip commit

    logic        is_md;
    logic        can_issue;
    logic        b_zero;
    logic [31:0] b_nz;       // divisor that is never zero, keeps the divider defined
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0] divs_q;
    logic [31:0] divs_r;
    logic [31:0] divu_q;
    logic [31:0] divu_r;

    assign is_md = (md.MDOp == OP_MULT) || (md.MDOp == OP_MULTU) ||
                   (md.MDOp == OP_DIV)  || (md.MDOp == OP_DIVU);
    assign can_issue = !md.Kill && !busy_q;

    assign md.Start = is_md && can_issue;
    assign md.Busy  = busy_q;
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;

    assign b_zero = (md.B == 32'd0);
    assign b_nz   = b_zero ? 32'd1 : md.B;

    assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    assign prod_u = {32'd0, md.A} * {32'd0, md.B};

    // Unsigned quotient/remainder
    assign divu_q = md.A / b_nz;
    assign divu_r = md.A % b_nz;

    // Signed quotient/remainder; the one overflow case is pinned explicitly
    always_comb begin
        divs_q = 32'd0;
        divs_r = 32'd0;
        if ((md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF)) begin
            divs_q = 32'h8000_0000;
            divs_r = 32'd0;
        end else begin
            divs_q = $unsigned($signed(md.A) / $signed(b_nz));
            divs_r = $unsigned($signed(md.A) % $signed(b_nz));
        end
    end

    // Issue, latency countdown and HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
            cnt    <= 4'd0;
            busy_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (busy_q) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                busy_q <= 1'b0;
                if (!dbz_q) begin
                    hi_q <= hi_tmp;
                    lo_q <= lo_tmp;
                end
            end
        end else if (!md.Kill) begin
            case (md.MDOp)
                OP_MULT: begin
                    {hi_tmp, lo_tmp} <= prod_s;
                    cnt    <= MULT_CNT;
                    busy_q <= 1'b1;
                    dbz_q  <= 1'b0;
                end
                OP_MULTU: begin
                    {hi_tmp, lo_tmp} <= prod_u;
                    cnt    <= MULT_CNT;
                    busy_q <= 1'b1;
                    dbz_q  <= 1'b0;
                end
                OP_DIV: begin
                    hi_tmp <= divs_r;
                    lo_tmp <= divs_q;
                    cnt    <= DIV_CNT;
                    busy_q <= 1'b1;
                    dbz_q  <= b_zero;
                end
                OP_DIVU: begin
                    hi_tmp <= divu_r;
                    lo_tmp <= divu_q;
                    cnt    <= DIV_CNT;
                    busy_q <= 1'b1;
                    dbz_q  <= b_zero;
                end
                OP_MTHI: hi_q <= md.A;
                OP_MTLO: lo_q <= md.A;
                OP_NONE: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic results, MTHI/MTLO,
// divide-by-zero, Kill, ops presented while busy, and reset mid-divide.
module tb_mult_div_unit;
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mult_div_unit_if md_if ();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if.slave)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic kill);
        md_if.MDOp = op;
        md_if.A    = a;
        md_if.B    = b;
        md_if.Kill = kill;
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Present a MD op with Start expected high, take the edge, return to NONE
    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b, 1'b0);
        check1({tag, "_start"}, md_if.Start, 1'b1);
        step();
        drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    // Busy must be high for exactly n cycles, then low
    task automatic expect_busy(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check1({tag, "_busy_hi"}, md_if.Busy, 1'b1);
            step();
        end
        check1({tag, "_busy_lo"}, md_if.Busy, 1'b0);
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check32({tag, "_hi"}, md_if.HI, hi);
        check32({tag, "_lo"}, md_if.LO, lo);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(OP_NONE, 32'd0, 32'd0, 1'b0);
        step();
        step();
        check1("reset_start", md_if.Start, 1'b0);
        reset = 1'b0;
        #1;
        check1("reset_busy", md_if.Busy, 1'b0);
        expect_hilo("reset", 32'd0, 32'd0);

        // MULT -2 * 3
        issue("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        expect_busy("mult", 5);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // MULTU same operands
        issue("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        expect_busy("multu", 5);
        expect_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        expect_busy("div", 10);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIVU 7 / 2
        issue("divu", OP_DIVU, 32'd7, 32'd2);
        expect_busy("divu", 10);
        expect_hilo("divu", 32'd1, 32'd3);

        // Signed overflow divide
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_busy("div_ovf", 10);
        expect_hilo("div_ovf", 32'd0, 32'h8000_0000);

        // MTHI then MTLO on consecutive cycles
        drive(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        check1("mthi_start", md_if.Start, 1'b0);
        step();
        check32("mthi_hi", md_if.HI, 32'h1234_5678);
        check32("mthi_lo_kept", md_if.LO, 32'h8000_0000);
        check1("mthi_busy", md_if.Busy, 1'b0);
        drive(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
        step();
        drive(OP_NONE, 32'd0, 32'd0, 1'b0);
        expect_hilo("mtlo", 32'h1234_5678, 32'h9ABC_DEF0);
        check1("mtlo_busy", md_if.Busy, 1'b0);

        // Divide by zero leaves HI/LO untouched
        drive(OP_MTHI, 32'd5, 32'd0, 1'b0);
        step();
        drive(OP_MTLO, 32'd6, 32'd0, 1'b0);
        step();
        issue("dbz", OP_DIV, 32'd100, 32'd0);
        expect_busy("dbz", 10);
        expect_hilo("dbz", 32'd5, 32'd6);

        // Killed MULT does nothing
        drive(OP_MULT, 32'd9, 32'd9, 1'b1);
        check1("kill_start", md_if.Start, 1'b0);
        step();
        drive(OP_NONE, 32'd0, 32'd0, 1'b0);
        check1("kill_busy", md_if.Busy, 1'b0);
        expect_hilo("kill", 32'd5, 32'd6);
        // Killed MTHI also does nothing
        drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        step();
        drive(OP_NONE, 32'd0, 32'd0, 1'b0);
        check32("kill_mthi_hi", md_if.HI, 32'd5);

        // MULT 3*4, with MTLO and DIV presented while busy
        issue("mult_bb", OP_MULT, 32'd3, 32'd4);
        check1("bb_busy1", md_if.Busy, 1'b1);
        drive(OP_MTLO, 32'h0000_DEAD, 32'd0, 1'b0);
        step();
        check32("bb_mtlo_ignored", md_if.LO, 32'd6);
        check1("bb_busy2", md_if.Busy, 1'b1);
        drive(OP_DIV, 32'd50, 32'd3, 1'b0);
        check1("bb_div_start", md_if.Start, 1'b0);
        step();
        drive(OP_NONE, 32'd0, 32'd0, 1'b0);
        expect_busy("mult_bb", 3);
        expect_hilo("mult_bb", 32'd0, 32'd12);
        // Back-to-back issue in the first non-busy cycle
        issue("div_bb", OP_DIV, 32'd100, 32'd7);
        expect_busy("div_bb", 10);
        expect_hilo("div_bb", 32'd2, 32'd14);

        // Reset during a DIV discards it
        issue("div_rst", OP_DIVU, 32'd9, 32'd2);
        step();
        step();
        check1("rst_busy_before", md_if.Busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check1("rst_busy", md_if.Busy, 1'b0);
        expect_hilo("rst", 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check32("rst_no_late_lo", md_if.LO, 32'd0);
        end
        check32("rst_no_late_hi", md_if.HI, 32'd0);
        check1("rst_busy_end", md_if.Busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
